perfcnt_resp: RTL and testbench
===============================

PERFCNT_RESP -- requirements
Module: perfcnt_resp

Interface
REQ-001 SHALL have parameter NTHREAD, default 2**(NTHREADIDMSB+1), number of hardware threads.
REQ-002 SHALL have parameter NCNT, default 8 (power of two), counters per thread; CW = log2(NCNT).
REQ-003 SHALL have port gclk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1; one clock (gclk), reset is synchronous and active-high.
REQ-005 SHALL have port rd_req, input, 1, read request strobe.
REQ-006 SHALL have port rd_addr, input, IO_AWIDTH-2, counter word address.
REQ-007 SHALL have port rd_tid, input, NTHREADIDMSB+1, thread of read.
REQ-008 SHALL have port rd_data, output, 64, response data.
REQ-009 SHALL have port rd_valid, output, 1, response strobe.
REQ-010 SHALL have port wr_valid, input, 1, control write strobe.
REQ-011 SHALL have port wr_inst, input, 32, control instruction.
REQ-012 SHALL have port wr_tid, input, NTHREADIDMSB+1, thread of control write.
REQ-013 SHALL have port wr_ready, output, 1, control write accepted when high.
REQ-014 SHALL have port ev, input, NCNT, per-counter increment events.
REQ-015 SHALL have port ev_tid, input, NTHREADIDMSB+1, thread owning ev.

Function
REQ-016 SHALL store NTHREAD x NCNT 64-bit counters.
REQ-017 SHALL, for each ev[i]=1 with mask[i]=1 in IDLE, add 1 to counter (ev_tid,i); all-ones wraps to 0.
REQ-018 SHALL respond to rd_req at cycle T with rd_valid=1 at T+1 for exactly one cycle, one response per request, back-to-back requests each cycle supported.
REQ-019 SHALL return counter (rd_tid, rd_addr[CW-1:0]) when rd_addr[IO_AWIDTH-3:CW]==0, else return 0 with rd_valid=1.
REQ-020 SHALL return the pre-increment value when read and increment hit the same counter in the same cycle.
REQ-021 SHALL drive rd_data=0 whenever rd_valid=0.
REQ-022 SHALL decode wr_inst[31:28] only when wr_valid=1 and wr_ready=1: 0x1 clear counter (wr_tid, wr_inst[CW-1:0]) in one cycle; 0x2 clear all NCNT counters of wr_tid; 0x3 mask <= wr_inst[NCNT-1:0]; other opcodes no effect.
REQ-023 SHALL implement FSM states INIT, IDLE, CLRT.
REQ-024 SHALL, in INIT, zero one entry per cycle over all NTHREAD*NCNT entries in (tid, index) order, then go to IDLE.
REQ-025 SHALL, on opcode 0x2 in IDLE, go to CLRT, zero index 0..NCNT-1 of the latched tid one per cycle, then return to IDLE after NCNT cycles.
REQ-026 SHALL hold wr_ready=1 only in IDLE; writes with wr_ready=0 are dropped.
REQ-027 SHALL ignore ev in INIT; in CLRT, increments to the thread being cleared are dropped, increments to other threads count.
REQ-028 SHALL give a clear priority over an increment to the same counter in the same cycle (result 0).
REQ-029 SHALL serve reads in all states; an entry not yet zeroed by an INIT sweep reads as 0 (INIT forces read data 0).

Reset
REQ-030 SHALL, when rst=1 at an edge, set rd_valid=0, rd_data=0, wr_ready=0, mask=all ones, FSM=INIT with sweep pointer 0, and drop any in-flight read; rst mid-CLRT restarts from INIT.

Verification
REQ-031 SHALL cover: rst then idle -> wr_ready=0 for exactly NTHREAD*NCNT cycles, then 1; every counter reads 0.
REQ-032 SHALL cover: ev=8'h01, ev_tid=3 for 5 cycles, then rd_req addr=0 tid=3 -> rd_valid next cycle, rd_data=5.
REQ-033 SHALL cover: counter preset via 2^64-2 increments (backdoor) plus 2 events -> reads 0 (wrap).
REQ-034 SHALL cover: wr_inst=0x2000_0000 tid=3 -> wr_ready low NCNT cycles, all tid-3 counters 0, tid-4 counters unchanged.
REQ-035 SHALL cover: wr_inst=0x3000_00FE then ev=8'hFF x3 -> counter 0 stays, counters 1..7 read 3; rd_addr=NCNT -> rd_data=0, rd_valid=1.
REQ-036 SHALL cover: same-cycle opcode 0x1 clear and ev on that counter -> 0; same-cycle read and ev -> old value returned, new value on next read.

Source files
------------

// File: rtl/perfcnt_resp.sv
// Per-thread 64-bit performance counters with a one-cycle read response port
// and an opcode-driven control port (clear one, clear thread, set mask).
module perfcnt_resp #(
  parameter int NTHREADIDMSB = 2,
  parameter int IO_AWIDTH    = 8,
  parameter int NTHREAD      = 2**(NTHREADIDMSB+1),
  parameter int NCNT         = 8
) (
  input  logic                    gclk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [IO_AWIDTH-3:0]    rd_addr,
  input  logic [NTHREADIDMSB:0]   rd_tid,
  output logic [63:0]             rd_data,
  output logic                    rd_valid,
  input  logic                    wr_valid,
  input  logic [31:0]             wr_inst,
  input  logic [NTHREADIDMSB:0]   wr_tid,
  output logic                    wr_ready,
  input  logic [NCNT-1:0]         ev,
  input  logic [NTHREADIDMSB:0]   ev_tid
);
  localparam int TW   = NTHREADIDMSB + 1;
  localparam int CW   = $clog2(NCNT);
  localparam int NENT = NTHREAD * NCNT;
  localparam int PW   = TW + CW;

  typedef enum logic [1:0] {INIT, IDLE, CLRT} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     clr_tid_q, clr_tid_d;
  logic [NCNT-1:0]   mask_q, mask_d;
  logic              rd_valid_q, rd_valid_d;
  logic [63:0]       rd_data_q, rd_data_d;
  logic [63:0]       cnt_all [NENT];
  logic [3:0]        op;
  logic              wr_fire;
  logic [PW-1:0]     rd_idx;
  logic              rd_hit;
  logic              unused_wr;

  assign op        = wr_inst[31:28];
  assign wr_ready  = (state_q == IDLE);
  assign wr_fire   = wr_valid && wr_ready;
  assign unused_wr = ^wr_inst[27:0];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_tid_d = clr_tid_q;
    mask_d    = mask_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PW'(NENT-1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      IDLE: begin
        if (wr_fire) begin
          case (op)
            4'h2: begin
              state_d   = CLRT;
              clr_tid_d = wr_tid;
              ptr_d     = '0;
            end
            4'h3:    mask_d = wr_inst[NCNT-1:0];
            default: ;
          endcase
        end
      end
      CLRT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PW'(NCNT-1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // One counter per (thread, index); clear always wins over increment.
  for (genvar k = 0; k < NENT; k++) begin : g_ent
    localparam logic [TW-1:0] KT = TW'(k / NCNT);
    localparam logic [CW-1:0] KI = CW'(k % NCNT);
    logic [63:0] cnt_q, cnt_d;
    logic        clr, inc;
    always_comb begin
      clr = (state_q == INIT && ptr_q == PW'(k)) ||
            (state_q == CLRT && clr_tid_q == KT && ptr_q[CW-1:0] == KI) ||
            (wr_fire && op == 4'h1 && wr_tid == KT && wr_inst[CW-1:0] == KI);
      inc = (state_q != INIT) && ev[KI] && mask_q[KI] && (ev_tid == KT) &&
            !(state_q == CLRT && clr_tid_q == KT);
      cnt_d = clr ? '0 : cnt_q + 64'(inc);
    end
    always_ff @(posedge gclk) cnt_q <= cnt_d;
    assign cnt_all[k] = cnt_q;
  end

  // Reads see the pre-update array, so a same-cycle increment is not visible.
  always_comb begin
    rd_idx     = {rd_tid, rd_addr[CW-1:0]};
    rd_hit     = rd_req && (state_q != INIT) && ((rd_addr >> CW) == '0) &&
                 ({1'b0, rd_idx} < (PW+1)'(NENT));
    rd_data_d  = rd_hit ? cnt_all[rd_idx] : '0;
    rd_valid_d = rd_req;
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      clr_tid_q  <= '0;
      mask_q     <= '1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_tid_q  <= clr_tid_d;
      mask_q     <= mask_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_perfcnt_resp.sv
// Directed bench for perfcnt_resp: vector table of reads plus hand sequences
// for sweep timing, thread clear, wrap, mask and same-cycle collisions.
module tb_perfcnt_resp;
  logic        gclk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [2:0]  rd_tid = '0;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_inst = '0;
  logic [2:0]  wr_tid = '0;
  logic        wr_ready;
  logic [7:0]  ev = '0;
  logic [2:0]  ev_tid = '0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  tid;
    logic [5:0]  addr;
    logic [63:0] exp;
    string       nm;
  } vec_t;
  vec_t vt[$];

  perfcnt_resp dut (
    .gclk(gclk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_tid(rd_tid),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_valid(wr_valid), .wr_inst(wr_inst),
    .wr_tid(wr_tid), .wr_ready(wr_ready), .ev(ev), .ev_tid(ev_tid)
  );

  always #5 gclk = ~gclk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] t, input logic [5:0] a, input logic [63:0] exp,
                    input string nm);
    @(negedge gclk);
    rd_req = 1'b1; rd_tid = t; rd_addr = a;
    @(negedge gclk);
    rd_req = 1'b0;
    check({nm, "_valid"}, 64'(rd_valid), 64'd1);
    check(nm, rd_data, exp);
  endtask

  // Called at the first negedge of a busy period; counts busy samples.
  task automatic wait_ready(input int exp, input string nm);
    int n = 0;
    while (!wr_ready && n < 500) begin
      n++;
      @(negedge gclk);
    end
    check(nm, 64'(n), 64'(exp));
  endtask

  task automatic wr(input logic [31:0] inst, input logic [2:0] t);
    @(negedge gclk);
    wr_valid = 1'b1; wr_inst = inst; wr_tid = t;
    @(negedge gclk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_ev(input logic [7:0] e, input logic [2:0] t, input int n);
    @(negedge gclk);
    ev = e; ev_tid = t;
    repeat (n) @(negedge gclk);
    ev = '0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vt.push_back('{3'd3, 6'(i), 64'd0, $sformatf("t3c%0d", i)});
      vt.push_back('{3'd4, 6'(i), 64'd2, $sformatf("t4c%0d", i)});
      vt.push_back('{3'd5, 6'(i), (i == 0) ? 64'd0 : 64'd3, $sformatf("t5c%0d", i)});
    end
    vt.push_back('{3'd5, 6'd8,  64'd0, "addr_ncnt"});
    vt.push_back('{3'd5, 6'h3f, 64'd0, "addr_high"});

    // Reset state, then sweep length; events during the sweep must not count.
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_data", rd_data, 64'd0);
    check("rst_ready", 64'(wr_ready), 64'd0);
    rst = 1'b0;
    ev = 8'hff; ev_tid = 3'd0;
    wait_ready(64, "init_len");
    ev = '0;
    for (int t = 0; t < 8; t++)
      for (int c = 0; c < 8; c++)
        rd(3'(t), 6'(c), 64'd0, $sformatf("zero_t%0dc%0d", t, c));

    // Basic counting.
    pulse_ev(8'h01, 3'd3, 5);
    rd(3'd3, 6'd0, 64'd5, "count5");

    // Wrap: preset t3c1 to all-ones minus one, then two events.
    @(negedge gclk);
    force dut.g_ent[25].cnt_d = 64'hffff_ffff_ffff_fffe;
    @(negedge gclk);
    release dut.g_ent[25].cnt_d;
    ev = 8'h02; ev_tid = 3'd3;
    repeat (2) @(negedge gclk);
    ev = '0;
    rd(3'd3, 6'd1, 64'd0, "wrap");

    // Populate t3 and t4, then clear t3 while hammering it with events
    // and a dropped single-clear to t4.
    pulse_ev(8'hff, 3'd3, 1);
    pulse_ev(8'hff, 3'd4, 2);
    rd(3'd3, 6'd7, 64'd1, "pre_clr_t3");
    @(negedge gclk);
    wr_valid = 1'b1; wr_inst = 32'h2000_0000; wr_tid = 3'd3;
    @(negedge gclk);
    wr_inst = 32'h1000_0000; wr_tid = 3'd4;
    ev = 8'hff; ev_tid = 3'd3;
    wait_ready(8, "clrt_len");
    wr_valid = 1'b0; ev = '0;

    // Mask out counter 0 and count three all-events on t5.
    wr(32'h3000_00fe, 3'd0);
    pulse_ev(8'hff, 3'd5, 3);
    foreach (vt[i]) rd(vt[i].tid, vt[i].addr, vt[i].exp, vt[i].nm);
    @(negedge gclk);
    check("idle_valid", 64'(rd_valid), 64'd0);
    check("idle_data", rd_data, 64'd0);

    // Single clear and increment on the same counter in the same cycle.
    @(negedge gclk);
    wr_valid = 1'b1; wr_inst = 32'h1000_0001; wr_tid = 3'd5;
    ev = 8'h02; ev_tid = 3'd5;
    @(negedge gclk);
    wr_valid = 1'b0; ev = '0;
    rd(3'd5, 6'd1, 64'd0, "clr_vs_inc");

    // Read and increment on the same counter in the same cycle.
    @(negedge gclk);
    rd_req = 1'b1; rd_tid = 3'd5; rd_addr = 6'd2;
    ev = 8'h04; ev_tid = 3'd5;
    @(negedge gclk);
    rd_req = 1'b0; ev = '0;
    check("rd_vs_inc", rd_data, 64'd3);
    rd(3'd5, 6'd2, 64'd4, "rd_after_inc");

    // Back-to-back reads.
    @(negedge gclk);
    rd_req = 1'b1; rd_tid = 3'd4; rd_addr = 6'd3;
    @(negedge gclk);
    rd_tid = 3'd5; rd_addr = 6'd4;
    check("b2b_0", rd_data, 64'd2);
    @(negedge gclk);
    rd_req = 1'b0;
    check("b2b_1", rd_data, 64'd3);

    // Reset in the middle of a thread clear restarts the full sweep.
    @(negedge gclk);
    wr_valid = 1'b1; wr_inst = 32'h2000_0000; wr_tid = 3'd6;
    @(negedge gclk);
    wr_valid = 1'b0;
    @(negedge gclk);
    rst = 1'b1;
    @(negedge gclk);
    rst = 1'b0;
    check("rst2_valid", 64'(rd_valid), 64'd0);
    wait_ready(64, "init_len2");
    rd(3'd5, 6'd2, 64'd0, "post_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
